bw_seq_multiplier: RTL and testbench



---
 rtl/bw_pkg.sv | 27 ++
 rtl/bw_pp_row.sv | 30 +++
 rtl/bw_seq_multiplier.sv | 168 ++++++++++++++++
 tb/tb_bw_seq_multiplier.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bw_pkg.sv
// Shared types and constants for the sequential Baugh-Wooley multiplier.
package bw_pkg;

    // Widest product the correction helper can describe (2*numBit must fit).
    localparam int BW_MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bw_state_t;

    // Baugh-Wooley correction constant 2^numBit + 2^(2*numBit-1) for signed
    // mode, zero for unsigned mode. Callers keep the low 2*numBit bits.
    function automatic logic [BW_MAX_W-1:0] bw_correction(input int num_bit, input logic is_signed);
        logic [BW_MAX_W-1:0] v_one;
        logic [BW_MAX_W-1:0] v_corr;
        v_one = {{(BW_MAX_W-1){1'b0}}, 1'b1};
        if (is_signed) begin
            v_corr = (v_one << num_bit) | (v_one << (2 * num_bit - 1));
        end else begin
            v_corr = {BW_MAX_W{1'b0}};
        end
        return v_corr;
    endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One Baugh-Wooley partial-product row: m AND a single multiplier bit, with
// the sign-position inversion applied in two's-complement mode.
module bw_pp_row
    import bw_pkg::*;
#(
    parameter int NUM_BIT = 16,
    parameter int ROW_W   = 5
) (
    input  logic [NUM_BIT-1:0] i_m,
    input  logic               i_n_bit,
    input  logic [ROW_W-1:0]   i_row,
    input  logic               i_signed,
    output logic [NUM_BIT-1:0] o_pp
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_BIT - 1);

    logic w_last_row;

    assign w_last_row = (i_row == LAST_ROW);

    // Build the row; invert a bit when exactly one of (row, column) is the sign position.
    always_comb begin
        o_pp = {NUM_BIT{1'b0}};
        for (int j = 0; j < NUM_BIT; j++) begin
            o_pp[j] = (i_m[j] & i_n_bit) ^ (i_signed & (w_last_row ^ (j == NUM_BIT - 1)));
        end
    end

endmodule

// File: rtl/bw_seq_multiplier.sv
// Sequential Baugh-Wooley multiplier: folds rowsPerCycle partial-product rows
// per clock into a registered accumulator, valid/ready on both sides.
module bw_seq_multiplier
    import bw_pkg::*;
#(
    parameter int numBit       = 16,
    parameter int rowsPerCycle = 1
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  signed_in,
    input  logic [numBit-1:0]     m_in,
    input  logic [numBit-1:0]     n_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [2*numBit-1:0]   o_out
);

    localparam int PROD_W = 2 * numBit;
    localparam int ROW_W  = $clog2(numBit + 1);
    localparam logic [ROW_W-1:0]    ROW_STEP = ROW_W'(rowsPerCycle);
    localparam logic [ROW_W-1:0]    ROW_END  = ROW_W'(numBit);
    localparam logic [numBit-1:0]   N_ONE    = {{(numBit-1){1'b0}}, 1'b1};
    localparam logic [BW_MAX_W-1:0] CORR_S_FULL = bw_correction(numBit, 1'b1);
    localparam logic [PROD_W-1:0]   CORR_S   = CORR_S_FULL[PROD_W-1:0];

    if ((numBit < 2) || ((numBit % rowsPerCycle) != 0) || (PROD_W > BW_MAX_W)) begin : g_bad_params
        $error("bw_seq_multiplier: numBit must be >= 2 and divisible by rowsPerCycle");
    end

    bw_state_t            r_state;
    bw_state_t            w_state_next;
    logic [numBit-1:0]    r_m;
    logic [numBit-1:0]    r_n;
    logic                 r_signed;
    logic [PROD_W-1:0]    r_acc;
    logic [PROD_W-1:0]    r_out;
    logic [ROW_W-1:0]     r_row;
    logic [ROW_W-1:0]     w_row_next;
    logic                 w_row_last;
    logic [PROD_W-1:0]    w_sum;
    logic                 w_ready;
    logic                 w_valid;
    logic [ROW_W-1:0]     w_row_idx [rowsPerCycle];
    logic [rowsPerCycle-1:0] w_n_bit;
    logic [numBit-1:0]    w_pp      [rowsPerCycle];

    assign w_row_next = r_row + ROW_STEP;
    assign w_row_last = (w_row_next == ROW_END);

    for (genvar k = 0; k < rowsPerCycle; k++) begin : g_row
        assign w_row_idx[k] = r_row + ROW_W'(k);
        // Shift-and-mask so an index past the top row reads as zero.
        assign w_n_bit[k]   = |(r_n & (N_ONE << w_row_idx[k]));

        bw_pp_row #(
            .NUM_BIT (numBit),
            .ROW_W   (ROW_W)
        ) u_pp_row (
            .i_m     (r_m),
            .i_n_bit (w_n_bit[k]),
            .i_row   (w_row_idx[k]),
            .i_signed(r_signed),
            .o_pp    (w_pp[k])
        );
    end

    // Adder chain: accumulator plus this cycle's shifted rows, modulo 2^PROD_W.
    always_comb begin
        w_sum = r_acc;
        for (int k = 0; k < rowsPerCycle; k++) begin
            w_sum = w_sum + ({{numBit{1'b0}}, w_pp[k]} << w_row_idx[k]);
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, count rows in RUN, wait for the sink in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_row_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (ready_in) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            IDLE:    w_ready = 1'b1;
            DONE:    w_valid = 1'b1;
            default: begin
                w_ready = 1'b0;
                w_valid = 1'b0;
            end
        endcase
    end

    assign ready_out = w_ready;
    assign valid_out = w_valid;
    assign o_out     = r_out;

    // Datapath: latch operands and seed the accumulator on accept, fold rows in
    // RUN, publish the finished sum on the last row. o_out holds until the next result.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_m      <= {numBit{1'b0}};
            r_n      <= {numBit{1'b0}};
            r_signed <= 1'b0;
            r_acc    <= {PROD_W{1'b0}};
            r_out    <= {PROD_W{1'b0}};
            r_row    <= {ROW_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_m      <= m_in;
                        r_n      <= n_in;
                        r_signed <= signed_in;
                        r_row    <= {ROW_W{1'b0}};
                        r_acc    <= signed_in ? CORR_S : {PROD_W{1'b0}};
                    end
                end
                RUN: begin
                    r_acc <= w_sum;
                    r_row <= w_row_next;
                    if (w_row_last) begin
                        r_out <= w_sum;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Directed bench for bw_seq_multiplier: a default 16x16 instance and an
// 8x8 instance folding four rows per cycle.
module tb_bw_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        a_valid_in, a_ready_out, a_signed_in, a_valid_out, a_ready_in;
    logic [15:0] a_m, a_n;
    logic [31:0] a_out;

    logic        b_valid_in, b_ready_out, b_signed_in, b_valid_out, b_ready_in;
    logic [7:0]  b_m, b_n;
    logic [15:0] b_out;

    int n_vec = 0;
    int n_err = 0;

    bw_seq_multiplier u_dut16 (
        .clk_in   (clk),
        .rstn_in  (rstn),
        .valid_in (a_valid_in),
        .ready_out(a_ready_out),
        .signed_in(a_signed_in),
        .m_in     (a_m),
        .n_in     (a_n),
        .valid_out(a_valid_out),
        .ready_in (a_ready_in),
        .o_out    (a_out)
    );

    bw_seq_multiplier #(.numBit(8), .rowsPerCycle(4)) u_dut8 (
        .clk_in   (clk),
        .rstn_in  (rstn),
        .valid_in (b_valid_in),
        .ready_out(b_ready_out),
        .signed_in(b_signed_in),
        .m_in     (b_m),
        .n_in     (b_n),
        .valid_out(b_valid_out),
        .ready_in (b_ready_in),
        .o_out    (b_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands to the 16-bit instance; returns at the negedge after the accept edge.
    task automatic a_accept(input logic sgn, input logic [15:0] m, input logic [15:0] n);
        int waited = 0;
        while (!a_ready_out && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("a_ready_before_accept", {31'b0, a_ready_out}, 32'd1);
        a_valid_in  = 1'b1;
        a_signed_in = sgn;
        a_m         = m;
        a_n         = n;
        @(negedge clk);
        a_valid_in  = 1'b0;
        a_signed_in = ~sgn;
        a_m         = 16'h5A5A;
        a_n         = 16'hA5A5;
    endtask

    // Wait for the 16-bit result, check latency and value, optionally take it.
    task automatic a_result(input logic [31:0] exp, input string tag, input logic ack);
        int lat = 0;
        while (!a_valid_out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd16);
        check_eq(tag, a_out, exp);
        if (ack) begin
            a_ready_in = 1'b1;
            @(negedge clk);
            a_ready_in = 1'b0;
            check_eq({tag, "_vdrop"}, {31'b0, a_valid_out}, 32'd0);
            check_eq({tag, "_keep"}, a_out, exp);
        end
    endtask

    // Full transaction on the 8-bit, four-rows-per-cycle instance.
    task automatic b_run(input logic sgn, input logic [7:0] m, input logic [7:0] n,
                         input logic [15:0] exp, input string tag);
        int waited = 0;
        int lat = 0;
        while (!b_ready_out && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        b_valid_in  = 1'b1;
        b_signed_in = sgn;
        b_m         = m;
        b_n         = n;
        @(negedge clk);
        b_valid_in  = 1'b0;
        b_m         = 8'hC3;
        b_n         = 8'h3C;
        while (!b_valid_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd2);
        check_eq(tag, {16'b0, b_out}, {16'b0, exp});
        b_ready_in = 1'b1;
        @(negedge clk);
        b_ready_in = 1'b0;
    endtask

    initial begin
        logic        r_sgn;
        logic [7:0]  r_m8, r_n8;
        logic [15:0] r_exp;

        rstn = 1'b0;
        a_valid_in = 1'b0; a_signed_in = 1'b0; a_m = 16'h0; a_n = 16'h0; a_ready_in = 1'b0;
        b_valid_in = 1'b0; b_signed_in = 1'b0; b_m = 8'h0;  b_n = 8'h0;  b_ready_in = 1'b0;
        #12;
        check_eq("rst_ready", {31'b0, a_ready_out}, 32'd1);
        check_eq("rst_valid", {31'b0, a_valid_out}, 32'd0);
        check_eq("rst_out", a_out, 32'h0);
        check_eq("rst_b_ready", {31'b0, b_ready_out}, 32'd1);
        check_eq("rst_b_out", {16'b0, b_out}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // 16x16 directed products
        a_accept(1'b1, 16'hFFFD, 16'h0005);
        a_result(32'hFFFFFFF1, "s_m3x5", 1'b1);
        a_accept(1'b0, 16'hFFFF, 16'hFFFF);
        a_result(32'hFFFE0001, "u_ffff_sq", 1'b1);
        a_accept(1'b1, 16'hFFFF, 16'hFFFF);
        a_result(32'h00000001, "s_m1_sq", 1'b1);
        a_accept(1'b1, 16'h8000, 16'h8000);
        a_result(32'h40000000, "s_min_sq", 1'b1);
        a_accept(1'b1, 16'h8000, 16'h7FFF);
        a_result(32'hC0008000, "s_min_max", 1'b1);

        // Backpressure: result held, new request ignored until the handshake
        a_accept(1'b0, 16'h1234, 16'h0010);
        a_result(32'h00012340, "bp", 1'b0);
        a_valid_in  = 1'b1;
        a_signed_in = 1'b1;
        a_m         = 16'h0007;
        a_n         = 16'hFFFE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_hold_out", a_out, 32'h00012340);
            check_eq("bp_hold_valid", {31'b0, a_valid_out}, 32'd1);
            check_eq("bp_not_ready", {31'b0, a_ready_out}, 32'd0);
        end
        a_ready_in = 1'b1;
        @(negedge clk);
        a_ready_in = 1'b0;
        check_eq("bp_release_valid", {31'b0, a_valid_out}, 32'd0);
        check_eq("bp_release_ready", {31'b0, a_ready_out}, 32'd1);
        check_eq("bp_release_out", a_out, 32'h00012340);
        @(negedge clk);
        a_valid_in = 1'b0;
        check_eq("bp_next_taken", {31'b0, a_ready_out}, 32'd0);
        a_result(32'hFFFFFFF2, "bp_next", 1'b1);

        // Asynchronous reset while row 7 is in flight
        a_accept(1'b1, 16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrun_rst_ready", {31'b0, a_ready_out}, 32'd1);
        check_eq("midrun_rst_valid", {31'b0, a_valid_out}, 32'd0);
        check_eq("midrun_rst_out", a_out, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        a_accept(1'b0, 16'h0003, 16'h0004);
        a_result(32'h0000000C, "rst_fresh", 1'b1);

        // 8x8, four rows per cycle; -127 * 127 = -16129
        b_run(1'b1, 8'h81, 8'h7F, 16'hC0FF, "b_s_m127x127");
        b_run(1'b0, 8'hFF, 8'hFF, 16'hFE01, "b_u_ff_sq");
        b_run(1'b1, 8'h80, 8'h80, 16'h4000, "b_s_min_sq");
        for (int i = 0; i < 12; i++) begin
            r_sgn = 1'($urandom_range(0, 1));
            r_m8  = 8'($urandom);
            r_n8  = 8'($urandom);
            if (r_sgn) begin
                r_exp = 16'($signed(r_m8) * $signed(r_n8));
            end else begin
                r_exp = {8'b0, r_m8} * {8'b0, r_n8};
            end
            b_run(r_sgn, r_m8, r_n8, r_exp, "b_sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
